// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and
// the command characters the parser matches against.
package uart_rx_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;
    localparam int LAST_TICK  = 15;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    // Command characters recognised by the downstream parser.
    localparam logic [7:0] CMD_SET  = 8'h73;  // 's'
    localparam logic [7:0] CMD_GET  = 8'h67;  // 'g'
    localparam logic [7:0] CMD_READ = 8'h72;  // 'r'
    localparam logic [7:0] CMD_OFF  = 8'h6F;  // 'o'

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-parser byte interface: data, good-byte strobe, error strobe, busy.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic       frame_err;
    logic       busy;

    modport master (output rx_data, new_rx_data, frame_err, busy);
    modport slave  (input  rx_data, new_rx_data, frame_err, busy);
endinterface

// File: rtl/uart_rx_baud_tick.sv
// Oversampling tick generator: one-cycle tick every CLK_HZ/(BAUD*16) clocks,
// restartable by clear. Shared with the companion transmitter.
module uart_baud_tick
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TOP = CW'(DIV - 1);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("uart_baud_tick: CLK_HZ too low for BAUD*16 (divider < 1)");
        end
    endgenerate

    logic [CW-1:0] cnt;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (rst || clear || cnt == '0) cnt <= TOP;
        else                           cnt <= cnt - 1'b1;
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled, mid-bit sampling, framing-error strobe.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx_i,
    uart_rx_if.master rx_bus
);
    generate
        if (OVERSAMPLE != uart_rx_pkg::OVERSAMPLE) begin : g_bad_os
            $error("uart_rx: OVERSAMPLE must be 16");
        end
    endgenerate

    logic [1:0] sync_ff;
    logic       rx_s;
    logic       tick, clear;
    state_t     state, state_nxt;
    logic [3:0] tick_cnt, tick_cnt_nxt;
    logic [2:0] bit_idx, bit_idx_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic [7:0] rx_data_q, rx_data_nxt;
    logic       new_q, new_nxt;
    logic       err_q, err_nxt;
    logic       stop_good;
`ifdef UART_RX_PARITY_EN
    logic       par_err, par_err_nxt;
    assign stop_good = rx_s && !par_err;
`else
    assign stop_good = rx_s;
`endif

    assign rx_s = sync_ff[1];

    uart_baud_tick #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff   <= 2'b11;  // idle line level, so reset never looks like a start edge
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data_q <= '0;
            new_q     <= 1'b0;
            err_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            sync_ff   <= {sync_ff[0], rx_i};
            state     <= state_nxt;
            tick_cnt  <= tick_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shreg     <= shreg_nxt;
            rx_data_q <= rx_data_nxt;
            new_q     <= new_nxt;
            err_q     <= err_nxt;
`ifdef UART_RX_PARITY_EN
            par_err   <= par_err_nxt;
`endif
        end
    end

    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        bit_idx_nxt  = bit_idx;
        shreg_nxt    = shreg;
        rx_data_nxt  = rx_data_q;
        new_nxt      = 1'b0;
        err_nxt      = 1'b0;
        clear        = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_nxt  = par_err;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt    = START;
                    tick_cnt_nxt = '0;
                    clear        = 1'b1;
`ifdef UART_RX_PARITY_EN
                    par_err_nxt  = 1'b0;
`endif
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt == 4'(MID_TICK)) begin
                        tick_cnt_nxt = '0;
                        bit_idx_nxt  = '0;
                        state_nxt    = rx_s ? IDLE : DATA;
                    end else begin
                        tick_cnt_nxt = tick_cnt + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    tick_cnt_nxt = tick_cnt + 4'd1;
                    if (tick_cnt == 4'(LAST_TICK)) begin
                        shreg_nxt   = {rx_s, shreg[7:1]};
                        bit_idx_nxt = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt = PARITY;
`else
                            state_nxt = STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    tick_cnt_nxt = tick_cnt + 4'd1;
                    if (tick_cnt == 4'(LAST_TICK)) begin
                        par_err_nxt = ^{shreg, rx_s};
                        state_nxt   = STOP;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    tick_cnt_nxt = tick_cnt + 4'd1;
                    if (tick_cnt == 4'(LAST_TICK)) begin
                        if (stop_good) begin
                            rx_data_nxt = shreg;
                            new_nxt     = 1'b1;
                        end else begin
                            err_nxt     = 1'b1;
                        end
                        state_nxt = rx_s ? IDLE : BREAK;
                    end
                end
            end
            BREAK: begin
                // Leave only after 16 consecutive high ticks.
                if (tick) begin
                    if (!rx_s)                           tick_cnt_nxt = '0;
                    else if (tick_cnt == 4'(LAST_TICK)) state_nxt    = IDLE;
                    else                                 tick_cnt_nxt = tick_cnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rx_bus.rx_data     = rx_data_q;
    assign rx_bus.new_rx_data = new_q;
    assign rx_bus.frame_err   = err_q;
    assign rx_bus.busy        = (state == DATA) || (state == PARITY) || (state == STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus hand-written corner
// sequences, with a scoreboard of expected strobes checked by a monitor.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int CLK_HZ  = 3_200_000;
    localparam int BAUD    = 100_000;
    localparam int BIT_CLK = CLK_HZ / BAUD;  // 32 clocks per bit

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_i = 1'b1;

    uart_rx_if bus ();

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .rx_i   (rx_i),
        .rx_bus (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic [7:0] data;     // input byte
        logic       stop_bit; // input stop-bit level
        int         gap;      // idle clocks after the frame
        logic       exp_err;  // expected: frame_err instead of new_rx_data
    } vec_t;

    ev_t        sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] last_good;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx_i = b;
        repeat (BIT_CLK) @(posedge clk);
    endtask

    task automatic send_bits(input logic [7:0] d, input logic par_bit, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_bit);
`else
        if (par_bit) rx_i = 1'b1;  // no parity slot in 8N1 frames
`endif
        drive_bit(stop_bit);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_bits(d, ^d, stop_bit);
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        ev_t ev;
        if (rst) begin
            last_good = 8'h00;
        end else if (bus.new_rx_data || bus.frame_err) begin
            check("strobe_exclusive", {31'd0, bus.new_rx_data & bus.frame_err}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_strobe", {30'd0, bus.new_rx_data, bus.frame_err}, 32'd0);
            end else begin
                ev = sb.pop_front();
                check("strobe_kind_err", {31'd0, bus.frame_err}, {31'd0, ev.is_err});
                if (ev.is_err) begin
                    check("rx_data_held", {24'd0, bus.rx_data}, {24'd0, last_good});
                end else begin
                    check("rx_data", {24'd0, bus.rx_data}, {24'd0, ev.data});
                    last_good = ev.data;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   lat;
        logic busy_seen;

        vecs[0] = '{8'h41, 1'b1, 0,  1'b0};
        vecs[1] = '{8'h00, 1'b1, 32, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 5,  1'b0};
        vecs[3] = '{8'h3C, 1'b0, 48, 1'b1};
        vecs[4] = '{8'hA5, 1'b1, 0,  1'b0};
        vecs[5] = '{8'h5A, 1'b1, 16, 1'b0};
        vecs[6] = '{8'hC3, 1'b0, 60, 1'b1};
        vecs[7] = '{8'h80, 1'b1, 32, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_data", {24'd0, bus.rx_data}, 32'h0);
        check("rst_new_rx_data", {31'd0, bus.new_rx_data}, 32'd0);
        check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        // 's' with latency and one-cycle strobe width
        sb.push_back('{1'b0, CMD_SET});
        fork
            send_frame(CMD_SET, 1'b1);
            begin
                lat = 0;
                while (!bus.new_rx_data && lat < 400) begin
                    @(negedge clk);
                    lat++;
                end
                check("latency_73_in_window", {31'd0, (lat >= 300 && lat <= 312)}, 32'd1);
                @(negedge clk);
                check("strobe_one_cycle", {31'd0, bus.new_rx_data}, 32'd0);
            end
        join
        repeat (BIT_CLK) @(posedge clk);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{vecs[i].exp_err, vecs[i].data});
            send_frame(vecs[i].data, vecs[i].stop_bit);
            rx_i = 1'b1;
            repeat (vecs[i].gap) @(posedge clk);
        end
        repeat (BIT_CLK) @(posedge clk);
        check("table_final_rx_data", {24'd0, bus.rx_data}, {24'd0, vecs[7].data});

        // Start-bit glitch: rejected, busy never rises
        rx_i = 1'b0;
        repeat (10) @(posedge clk);
        rx_i = 1'b1;
        busy_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            busy_seen = busy_seen | bus.busy;
        end
        check("glitch_busy", {31'd0, busy_seen}, 32'd0);
        check("glitch_state_idle", {29'd0, dut.state}, {29'd0, IDLE});

        // Bad stop bit followed by a held-low break
        sb.push_back('{1'b1, CMD_GET});
        send_frame(CMD_GET, 1'b0);
        repeat (200) @(posedge clk);
        rx_i = 1'b1;
        repeat (20) @(posedge clk);
        #1 check("break_still_waiting", {29'd0, dut.state}, {29'd0, BREAK});
        repeat (20) @(posedge clk);
        #1 check("break_back_to_idle", {29'd0, dut.state}, {29'd0, IDLE});
        check("break_rx_data_kept", {24'd0, bus.rx_data}, {24'd0, vecs[7].data});

        // Back-to-back frames, zero idle gap
        sb.push_back('{1'b0, CMD_GET});
        sb.push_back('{1'b0, 8'h00});
        sb.push_back('{1'b0, 8'h05});
        send_frame(CMD_GET, 1'b1);
        send_frame(8'h00, 1'b1);
        send_frame(8'h05, 1'b1);
        repeat (BIT_CLK) @(posedge clk);

        // Reset in the middle of bit 4 of 0xAA, then a clean 'o'
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'hAA >> i));
        rx_i = 1'b0;
        repeat (BIT_CLK / 2) @(posedge clk);
        rst  = 1'b1;
        rx_i = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_rx_data", {24'd0, bus.rx_data}, 32'h0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_state", {29'd0, dut.state}, {29'd0, IDLE});
        rst = 1'b0;
        repeat (2 * BIT_CLK) @(posedge clk);
        sb.push_back('{1'b0, CMD_OFF});
        send_frame(CMD_OFF, 1'b1);
        repeat (BIT_CLK) @(posedge clk);
        check("after_rst_rx_data", {24'd0, bus.rx_data}, {24'd0, CMD_OFF});

`ifdef UART_RX_PARITY_EN
        // Even parity: correct bit accepted, flipped bit gives frame_err only
        sb.push_back('{1'b0, CMD_READ});
        send_bits(CMD_READ, 1'b0, 1'b1);
        repeat (BIT_CLK) @(posedge clk);
        sb.push_back('{1'b1, CMD_READ});
        send_bits(CMD_READ, 1'b1, 1'b1);
        repeat (BIT_CLK) @(posedge clk);
        check("parity_rx_data", {24'd0, bus.rx_data}, {24'd0, CMD_READ});
`endif

        repeat (100) @(posedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
